// File: rtl/watpixels_pkg.sv
// watpixels_pkg
// Shared definitions for the demo scene scheduler.
//   sched_state_t : scheduler states (DWELL, FADE_OUT, SWITCH, FADE_IN)
//   FADE_MAX      : full brightness level
//   FADE_MIN      : black level
package watpixels_pkg;

    typedef enum logic [1:0] {
        DWELL    = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } sched_state_t;

    localparam logic [3:0] FADE_MAX = 4'd15;
    localparam logic [3:0] FADE_MIN = 4'd0;

endpackage

// File: rtl/scene_scheduler_btn_sync_edge.sv
// btn_sync_edge
// Two-flop synchronizer for a raw push button, with an optional
// rising-edge detector on the synchronized level.
// Parameters:
//   EDGE_EN : 0 -> dout is the synchronized level
//             1 -> dout is a one-cycle pulse on each synchronized rising edge
// Ports:
//   clk   in  : clock
//   rst_n in  : asynchronous active-low reset
//   din   in  : raw asynchronous button input
//   dout  out : synchronized level or rising-edge pulse
module btn_sync_edge #(
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], din};
        end
    end

    generate
        if (EDGE_EN) begin : g_edge
            logic prev;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev <= 1'b0;
                end else begin
                    prev <= sync[1];
                end
            end

            assign dout = sync[1] & ~prev;
        end else begin : g_level
            assign dout = sync[1];
        end
    endgenerate

endmodule

// File: rtl/scene_scheduler.sv
// scene_scheduler
// Frame-synchronous scheduler that steps the demo through its pattern
// scenes. A scene is held for DWELL_FRAMES frames (or until a skip
// request), then the advance is wrapped in a fade-out / fade-in. All
// schedule state changes happen only on frame_start cycles.
// Build option:
//   SCENE_SCHED_FADE_EN defined   -> DWELL/FADE_OUT/SWITCH/FADE_IN sequence
//   SCENE_SCHED_FADE_EN undefined -> scene advances directly at dwell expiry,
//                                    fade_level is constant 15
// Parameters:
//   NUM_SCENES   : scenes cycled, 1..4
//   DWELL_FRAMES : frames a scene is held at full brightness, >= 1
// Ports:
//   clk          in  : pixel clock
//   rst_n        in  : asynchronous active-low reset
//   frame_start  in  : one-cycle pulse per frame
//   pause        in  : raw button, freezes the schedule
//   resume       in  : raw button, unfreezes the schedule
//   skip         in  : raw button, requests an early advance
//   scene_sel    out : current scene index
//   fade_level   out : brightness, 15 = full, 0 = black
//   scene_change out : one-cycle pulse when scene_sel takes a new value
//   frozen       out : schedule is paused
module scene_scheduler
    import watpixels_pkg::*;
#(
    parameter int NUM_SCENES   = 4,
    parameter int DWELL_FRAMES = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       pause,
    input  logic       resume,
    input  logic       skip,
    output logic [1:0] scene_sel,
    output logic [3:0] fade_level,
    output logic       scene_change,
    output logic       frozen
);

    localparam int               CNT_W      = $clog2(DWELL_FRAMES + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);
    localparam logic [1:0]       LAST_SCENE = 2'(NUM_SCENES - 1);

    logic             pause_s;
    logic             resume_s;
    logic             skip_rise;
    logic             frame_go;
    logic             dwell_done;
    logic             skip_pend;
    logic [CNT_W-1:0] dwell_cnt;
    logic [1:0]       next_scene;

    btn_sync_edge #(.EDGE_EN(1'b0)) u_pause_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pause),
        .dout (pause_s)
    );

    btn_sync_edge #(.EDGE_EN(1'b0)) u_resume_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (resume),
        .dout (resume_s)
    );

    btn_sync_edge #(.EDGE_EN(1'b1)) u_skip_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (skip),
        .dout (skip_rise)
    );

    // frozen only changes while unfrozen when pause_s is high, so a frame
    // coinciding with a freeze is dropped; while frozen every frame is dropped.
    assign frame_go   = frame_start & ~frozen & ~pause_s;
    assign dwell_done = (dwell_cnt == DWELL_LAST) || skip_pend;
    assign next_scene = (scene_sel == LAST_SCENE) ? 2'd0 : scene_sel + 2'd1;

    // pause has priority over resume when both are seen together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen <= 1'b0;
        end else if (pause_s) begin
            frozen <= 1'b1;
        end else if (resume_s) begin
            frozen <= 1'b0;
        end
    end

`ifdef SCENE_SCHED_FADE_EN

    sched_state_t state;

    // Skip edges only arm the pending flag in DWELL; an edge seen during the
    // fade states clears it so it cannot trigger a second advance later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= DWELL;
            dwell_cnt    <= '0;
            skip_pend    <= 1'b0;
            scene_sel    <= 2'd0;
            fade_level   <= FADE_MAX;
            scene_change <= 1'b0;
        end else begin
            scene_change <= 1'b0;
            if (skip_rise) begin
                skip_pend <= (state == DWELL);
            end
            if (frame_go) begin
                case (state)
                    DWELL: begin
                        if (dwell_done) begin
                            state     <= FADE_OUT;
                            dwell_cnt <= '0;
                            skip_pend <= 1'b0;
                        end else begin
                            dwell_cnt <= dwell_cnt + CNT_W'(1);
                        end
                    end
                    FADE_OUT: begin
                        if (fade_level != FADE_MIN) begin
                            fade_level <= fade_level - 4'd1;
                        end
                        if (fade_level <= FADE_MIN + 4'd1) begin
                            state <= SWITCH;
                        end
                    end
                    SWITCH: begin
                        scene_sel    <= next_scene;
                        scene_change <= 1'b1;
                        fade_level   <= FADE_MIN;
                        state        <= FADE_IN;
                    end
                    FADE_IN: begin
                        if (fade_level != FADE_MAX) begin
                            fade_level <= fade_level + 4'd1;
                        end
                        if (fade_level >= FADE_MAX - 4'd1) begin
                            state <= DWELL;
                        end
                    end
                    default: begin
                        state <= DWELL;
                    end
                endcase
            end
        end
    end

`else

    assign fade_level = FADE_MAX;

    // Without fading the scheduler is permanently in DWELL and the scene
    // advances on the very frame the dwell expires or a skip is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt    <= '0;
            skip_pend    <= 1'b0;
            scene_sel    <= 2'd0;
            scene_change <= 1'b0;
        end else begin
            scene_change <= 1'b0;
            if (skip_rise) begin
                skip_pend <= 1'b1;
            end
            if (frame_go) begin
                if (dwell_done) begin
                    scene_sel    <= next_scene;
                    scene_change <= 1'b1;
                    dwell_cnt    <= '0;
                    skip_pend    <= 1'b0;
                end else begin
                    dwell_cnt <= dwell_cnt + CNT_W'(1);
                end
            end
        end
    end

`endif

endmodule

// File: doc/scene_scheduler.md
# scene_scheduler

Frame-synchronous scheduler that sequences the demo through its pattern scenes. It drives the 2-bit scene select consumed by `pattern_selector` and a 4-bit fade level for output dimming. Scenes advance automatically after a dwell period or on a debounced skip request, and the advance is wrapped in a fade-out/fade-in. It sits beside `speed_controller`, fed by `vga_timing`'s `frame_start`, and all state changes occur only on frame boundaries.

## Interface
- `NUM_SCENES`, 4: number of scenes cycled, legal 1..4.
- `DWELL_FRAMES`, 300: frames a scene is held at full brightness, legal ≥ 1.
- `clk` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: one-cycle pulse per frame, synchronous to `clk`.
- `pause` in 1: raw button; freezes the schedule.
- `resume` in 1: raw button; unfreezes the schedule.
- `skip` in 1: raw button; requests an early scene advance.
- `scene_sel` out 2: current scene index, registered.
- `fade_level` out 4: brightness, 15 = full and 0 = black, registered.
- `scene_change` out 1: one-cycle pulse on the cycle `scene_sel` takes a new value.
- `frozen` out 1: schedule is paused, registered.

## Operation
- `pause`, `resume` and `skip` each pass through a 2-flop synchronizer. `skip` is also rising-edge detected.
- Frozen flag:
  - Set by synced `pause`, cleared by synced `resume`.
  - If both are high in the same cycle, `pause` wins.
  - While frozen, every counter, the state, `fade_level` and `scene_sel` hold.
- Skip pending:
  - Set by a skip rising edge.
  - Cleared when consumed in DWELL.
  - Also cleared by any edge that arrives during FADE_OUT, SWITCH or FADE_IN, which are discarded.
  - A pending skip survives a freeze and is honoured after resume.
- Four states, evaluated only on `frame_start` cycles when not frozen:
  - DWELL: `fade_level` = 15. The dwell counter increments.
    - Go to FADE_OUT and clear the dwell counter when the counter reaches `DWELL_FRAMES-1` or skip is pending.
    - The skip is consumed on that edge.
  - FADE_OUT: `fade_level` decrements by 1 per frame. On the frame it reaches 0, go to SWITCH.
  - SWITCH:
    - `scene_sel` ← (`scene_sel`+1) mod `NUM_SCENES`, wrapping `NUM_SCENES-1` → 0.
    - Pulse `scene_change`. `fade_level` stays 0. Go to FADE_IN.
  - FADE_IN: `fade_level` increments by 1 per frame. On the frame it reaches 15, go to DWELL.
- `NUM_SCENES`=1: the full sequence still runs; `scene_sel` stays 0 and `scene_change` still pulses.
- `fade_level` saturates: it never underflows below 0 or overflows above 15.
- Dwell counter width is `$clog2(DWELL_FRAMES+1)`.

## Timing
- Reset values:
  - `scene_sel` = 0, `fade_level` = 15, `scene_change` = 0, `frozen` = 0.
  - State DWELL, dwell counter 0, skip pending 0, synchronizer flops 0.
- Asserting reset mid-fade returns to the reset values immediately (asynchronous).
- Outputs update on the clock edge that samples `frame_start` = 1. They are stable for the whole frame, and `scene_change` is high only in the following cycle.
- Button latency: 2 cycles of synchronizer, plus 1 cycle to the frozen or skip-pending register.
- Full auto cycle: `DWELL_FRAMES` frames in DWELL + 15 frames in FADE_OUT + 1 frame in SWITCH + 15 frames in FADE_IN.
- Skip honoured at the first non-frozen `frame_start` in DWELL after the pending flag sets.
- `frame_start` is ignored in the same cycle that `frozen` changes. The new frozen value governs from the next `frame_start` on.

## Configuration
- `SCENE_SCHED_FADE_EN` defined: the four-state fade sequence above applies.
- `SCENE_SCHED_FADE_EN` undefined:
  - FADE_OUT, SWITCH and FADE_IN are removed and `fade_level` is a constant 15.
  - On DWELL expiry or skip, `scene_sel` advances at that same `frame_start`, `scene_change` pulses, and the dwell counter clears.

## Structure
- `watpixels_pkg` holds:
  - the state enum (DWELL, FADE_OUT, SWITCH, FADE_IN);
  - `FADE_MAX` = 4'd15;
  - `FADE_MIN` = 4'd0.
- One sub-module, `btn_sync_edge`: a 2-flop synchronizer with optional rising-edge output, instantiated three times.

## Test plan
- Auto advance, fade enabled (NUM_SCENES=3, DWELL_FRAMES=4), run 3 full cycles:
  - `scene_sel` goes 0 → 1 → 2 → 0.
  - 35 frames per cycle.
  - `fade_level` traces 15,…,0,0,1,…,15.
- Skip: edge on `skip` at frame 1 of DWELL → FADE_OUT begins at the next `frame_start`. A second skip edge during FADE_OUT is discarded, so exactly one advance occurs.
- Pause/resume:
  - Pause at `fade_level`=9 during FADE_OUT, then 10 `frame_start` pulses → `fade_level` stays 9.
  - Resume → the next frame gives 8.
  - `pause` and `resume` high together → `frozen` = 1.
- Reset mid-FADE_IN at `fade_level`=6, `scene_sel`=2 → immediately `fade_level` = 15, `scene_sel` = 0, `scene_change` = 0.
- Fade disabled (macro off, DWELL_FRAMES=2) → `scene_sel` advances every 2 frames, `fade_level` is always 15, and `scene_change` pulses one cycle after each advancing `frame_start`.
- NUM_SCENES=1 → `scene_sel` stays 0 and `scene_change` pulses once per cycle.
